mem_read_arbiter: RTL

- Parametrised N-channel memory read port with pipelined, tag-routed responses.
- Sits between several read requestors (instruction fetch, load unit, debug) and one synchronous-read memory port with fixed latency.
- Arbitrates one request per cycle, round-robin or fixed-priority.
- Tracks which channel owns each in-flight read and steers returning data to that channel; up to MEM_LATENCY reads are outstanding at once.

---
 rtl/mem_read_arbiter.sv | 103 ++++++++++
 1 files changed

// File: rtl/mem_read_arbiter.sv
// mem_read_arbiter: N-channel read arbiter in front of a fixed-latency,
// in-order synchronous memory port. One grant per cycle (round-robin or
// fixed priority). A tag pipeline as deep as the memory latency records
// which channel owns each in-flight read, so returning data is steered
// back to that channel.
module mem_read_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int NUM_CH      = 2,
  parameter int MEM_LATENCY = 1,
  parameter int ARB_MODE    = 0
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_CH-1:0]                   ch_req_valid,
  input  logic [NUM_CH-1:0][ADDR_WIDTH-1:0]   ch_req_addr,
  output logic [NUM_CH-1:0]                   ch_req_ready,
  output logic [NUM_CH-1:0]                   ch_resp_valid,
  output logic [DATA_WIDTH-1:0]               ch_resp_data,
  output logic                                mem_rd_en,
  output logic [ADDR_WIDTH-1:0]               mem_rd_addr,
  input  logic [DATA_WIDTH-1:0]               mem_rd_data,
  output logic                                busy
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int LAST = MEM_LATENCY - 1;

  logic [CH_W-1:0]                    rr_ptr_q, rr_ptr_d;
  logic                               gnt_vld;
  logic [CH_W-1:0]                    gnt_id;
  logic                               gnt_en;
  logic [CH_W-1:0]                    idx;
  logic [MEM_LATENCY-1:0]             vld_q;
  logic [MEM_LATENCY-1:0][CH_W-1:0]   id_q;

  // Pick the winning channel: scan from rr_ptr with wrap (round-robin),
  // or from channel 0 (fixed priority). First valid hit wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    idx     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ARB_MODE == 0) idx = CH_W'((int'(rr_ptr_q) + i) % NUM_CH);
      else               idx = CH_W'(i);
      if (!gnt_vld && ch_req_valid[idx]) begin
        gnt_vld = 1'b1;
        gnt_id  = idx;
      end
    end
  end

  // Grant, memory strobe and address; all held low while reset is asserted.
  always_comb begin
    gnt_en       = gnt_vld & rst_n;
    ch_req_ready = '0;
    mem_rd_en    = gnt_en;
    mem_rd_addr  = '0;
    if (gnt_en) begin
      ch_req_ready[gnt_id] = 1'b1;
      mem_rd_addr          = ch_req_addr[gnt_id];
    end
  end

  // Next round-robin pointer: one past the winner, wrapping at NUM_CH-1.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (ARB_MODE == 0 && gnt_vld) begin
      if (gnt_id == CH_W'(NUM_CH - 1)) rr_ptr_d = '0;
      else                             rr_ptr_d = CH_W'(gnt_id + 1'b1);
    end
  end

  // Pointer and tag pipeline; reset discards every in-flight tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
      vld_q    <= '0;
      id_q     <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      vld_q[0] <= gnt_vld;
      id_q[0]  <= gnt_id;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        id_q[i]  <= id_q[i-1];
      end
    end
  end

  // Response steering: last tag stage selects the channel, data passes through.
  always_comb begin
    ch_resp_valid = '0;
    ch_resp_data  = '0;
    if (vld_q[LAST]) begin
      ch_resp_valid[id_q[LAST]] = 1'b1;
      ch_resp_data              = mem_rd_data;
    end
  end

  assign busy = |vld_q;

endmodule
